// File: rtl/ahb_mst_pkg.sv
// Shared types and constants for the pipelined AHB-Lite master.
// Optional ERROR-response handling is enabled with AHB_MST_ERR_RESP_EN.
package ahb_mst_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HALF  = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   // Command slots sized for the widest supported bus; tops narrow on use
   localparam int CMD_ADDR_W = 64;
   localparam int CMD_DATA_W = 64;

   typedef struct packed {
      logic [CMD_ADDR_W-1:0] addr;
      logic                  write;
      logic [2:0]            size;
      logic [CMD_DATA_W-1:0] wdata;
   } ahb_cmd_t;

   function automatic logic [2:0] clamp_size(
      input logic [2:0] size,
      input logic [2:0] max_size
   );
      return (size > max_size) ? max_size : size;
   endfunction

   function automatic logic [CMD_ADDR_W-1:0] align_addr(
      input logic [CMD_ADDR_W-1:0] addr,
      input logic [2:0]            size
   );
      return addr & ~((CMD_ADDR_W'(1) << size) - CMD_ADDR_W'(1));
   endfunction

endpackage

// File: rtl/ahb_mst_cmd_fifo.sv
// Synchronous command FIFO for the AHB master; DEPTH must be a power of 2.
// Same design under every build option, including AHB_MST_ERR_RESP_EN.
module ahb_mst_cmd_fifo
   import ahb_mst_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     i_clk_ahb,
   input  logic                     i_rstn_ahb,
   input  logic                     i_push,
   input  ahb_cmd_t                 i_cmd,
   input  logic                     i_pop,
   output ahb_cmd_t                 o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   ahb_cmd_t         mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(i_push);
      rd_ptr_d = rd_ptr_q + PW'(i_pop);
      cnt_d    = cnt_q + CW'(i_push) - CW'(i_pop);
   end

   always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
      if (!i_rstn_ahb) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge i_clk_ahb) begin
      if (i_push) begin
         mem_q[wr_ptr_q] <= i_cmd;
      end
   end

   assign o_head  = mem_q[rd_ptr_q];
   assign o_full  = (cnt_q == CW'(DEPTH));
   assign o_empty = (cnt_q == '0);
   assign o_count = cnt_q;

endmodule

// File: rtl/ahb_master_pipe.sv
// Pipelined AHB-Lite master: command FIFO feeding registered A and D stages.
// Define AHB_MST_ERR_RESP_EN to honour two-cycle ERROR responses on HRESP.
module ahb_master_pipe
   import ahb_mst_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              i_clk_ahb,
   input  logic              i_rstn_ahb,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_rd0_wr1,
   input  logic [2:0]        i_size,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_rsp_valid,
   output logic              o_rsp_write,
   output logic              o_rsp_err,
   output logic [DATA_W-1:0] o_rd_data,
   output logic [ADDR_W-1:0] HADDR,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [1:0]        HTRANS,
   output logic              HMASTLOCK,
   output logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   input  logic              HRESP,
   input  logic [DATA_W-1:0] HRDATA
);

   localparam logic [2:0] MAX_SZ = 3'($clog2(DATA_W / 8));

   ahb_cmd_t                    push_cmd;
   ahb_cmd_t                    fifo_head;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
   logic                        push;
   logic                        pop;
   logic                        adv;
   logic                        done;
   logic                        err_hit;
   logic                        err_first;
   logic [2:0]                  push_sz;

   htrans_t           htrans_q, htrans_d;
   logic              a_pend_q, a_pend_d;
   logic [ADDR_W-1:0] a_addr_q, a_addr_d;
   logic              a_write_q, a_write_d;
   logic [2:0]        a_size_q, a_size_d;
   logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
   logic              d_valid_q, d_valid_d;
   logic              d_write_q, d_write_d;
   logic [DATA_W-1:0] hwdata_q, hwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_write_q, rsp_write_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   assign push = i_valid && !fifo_full;

   always_comb begin
      push_sz        = clamp_size(i_size, MAX_SZ);
      push_cmd       = '0;
      push_cmd.addr  = align_addr(CMD_ADDR_W'(i_addr), push_sz);
      push_cmd.write = i_rd0_wr1;
      push_cmd.size  = push_sz;
      push_cmd.wdata = CMD_DATA_W'(i_wr_data);
   end

   ahb_mst_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk_ahb  (i_clk_ahb),
      .i_rstn_ahb (i_rstn_ahb),
      .i_push     (push),
      .i_cmd      (push_cmd),
      .i_pop      (pop),
      .o_head     (fifo_head),
      .o_full     (fifo_full),
      .o_empty    (fifo_empty),
      .o_count    (fifo_cnt)
   );

`ifdef AHB_MST_ERR_RESP_EN
   assign err_hit   = HRESP;
   assign err_first = d_valid_q && HRESP && !HREADY;
   logic unused_ok;
   assign unused_ok = ^{fifo_head, fifo_cnt};
`else
   assign err_hit   = 1'b0;
   assign err_first = 1'b0;
   logic unused_ok;
   assign unused_ok = ^{fifo_head, fifo_cnt, HRESP};
`endif

   assign adv  = HREADY || !d_valid_q;
   assign done = d_valid_q && HREADY;

   always_comb begin
      htrans_d  = htrans_q;
      a_pend_d  = a_pend_q;
      a_addr_d  = a_addr_q;
      a_write_d = a_write_q;
      a_size_d  = a_size_q;
      a_wdata_d = a_wdata_q;
      d_valid_d = d_valid_q;
      d_write_d = d_write_q;
      hwdata_d  = hwdata_q;
      pop       = 1'b0;
      if (adv) begin
         d_valid_d = (htrans_q == NONSEQ);
         d_write_d = (htrans_q == NONSEQ) && a_write_q;
         if (htrans_q == NONSEQ) begin
            hwdata_d = a_wdata_q;
         end
         // A command parked by an ERROR is re-driven before the FIFO moves
         if (a_pend_q && htrans_q == IDLE) begin
            htrans_d = NONSEQ;
         end else if (!fifo_empty) begin
            pop       = 1'b1;
            a_pend_d  = 1'b1;
            htrans_d  = NONSEQ;
            a_addr_d  = fifo_head.addr[ADDR_W-1:0];
            a_write_d = fifo_head.write;
            a_size_d  = fifo_head.size;
            a_wdata_d = fifo_head.wdata[DATA_W-1:0];
         end else begin
            a_pend_d = 1'b0;
            htrans_d = IDLE;
         end
      end else if (err_first) begin
         htrans_d = IDLE;
      end
   end

   always_comb begin
      rsp_valid_d = done;
      rsp_write_d = done && d_write_q;
      rsp_err_d   = done && err_hit;
      rd_data_d   = '0;
      if (done && !d_write_q && !err_hit) begin
         rd_data_d = HRDATA;
      end
   end

   always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
      if (!i_rstn_ahb) begin
         htrans_q    <= IDLE;
         a_pend_q    <= 1'b0;
         a_addr_q    <= '0;
         a_write_q   <= 1'b0;
         a_size_q    <= HSIZE_WORD;
         a_wdata_q   <= '0;
         d_valid_q   <= 1'b0;
         d_write_q   <= 1'b0;
         hwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         htrans_q    <= htrans_d;
         a_pend_q    <= a_pend_d;
         a_addr_q    <= a_addr_d;
         a_write_q   <= a_write_d;
         a_size_q    <= a_size_d;
         a_wdata_q   <= a_wdata_d;
         d_valid_q   <= d_valid_d;
         d_write_q   <= d_write_d;
         hwdata_q    <= hwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_err_q   <= rsp_err_d;
         rd_data_q   <= rd_data_d;
      end
   end

   assign o_ready     = !fifo_full;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_write = rsp_write_q;
   assign o_rsp_err   = rsp_err_q;
   assign o_rd_data   = rd_data_q;
   assign HADDR       = a_addr_q;
   assign HWRITE      = a_write_q;
   assign HSIZE       = a_size_q;
   assign HBURST      = HBURST_SINGLE;
   assign HTRANS      = htrans_q;
   assign HMASTLOCK   = 1'b0;
   assign HWDATA      = hwdata_q;

endmodule

// File: tb/tb_ahb_master_pipe.sv
// Self-checking bench for ahb_master_pipe: vector table, scoreboard, corner sequences.
// Build with AHB_MST_ERR_RESP_EN defined to exercise the ERROR-response sequence.
module tb_ahb_master_pipe;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic [AW-1:0] i_addr = '0;
   logic          i_rd0_wr1 = 1'b0;
   logic [2:0]    i_size = 3'd2;
   logic [DW-1:0] i_wr_data = '0;
   logic          o_rsp_valid;
   logic          o_rsp_write;
   logic          o_rsp_err;
   logic [DW-1:0] o_rd_data;
   logic [AW-1:0] HADDR;
   logic          HWRITE;
   logic [2:0]    HSIZE;
   logic [2:0]    HBURST;
   logic [1:0]    HTRANS;
   logic          HMASTLOCK;
   logic [DW-1:0] HWDATA;
   logic          HREADY = 1'b1;
   logic          HRESP = 1'b0;
   logic [DW-1:0] HRDATA;

   ahb_master_pipe #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .FIFO_DEPTH (4)
   ) dut (
      .i_clk_ahb   (clk),
      .i_rstn_ahb  (rstn),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_addr      (i_addr),
      .i_rd0_wr1   (i_rd0_wr1),
      .i_size      (i_size),
      .i_wr_data   (i_wr_data),
      .o_rsp_valid (o_rsp_valid),
      .o_rsp_write (o_rsp_write),
      .o_rsp_err   (o_rsp_err),
      .o_rd_data   (o_rd_data),
      .HADDR       (HADDR),
      .HWRITE      (HWRITE),
      .HSIZE       (HSIZE),
      .HBURST      (HBURST),
      .HTRANS      (HTRANS),
      .HMASTLOCK   (HMASTLOCK),
      .HWDATA      (HWDATA),
      .HREADY      (HREADY),
      .HRESP       (HRESP),
      .HRDATA      (HRDATA)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [31:0] exp_addr;
      logic [2:0]  exp_size;
   } vec_t;

   typedef struct {
      logic        wr;
      logic        err;
      logic [31:0] data;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
   } aph_t;

   vec_t tbl [8];
   rsp_t sb [$];
   aph_t aq [$];
   int   rsp_cyc [$];
   int   ns_cyc [$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rsp_cnt = 0;
   logic aph_en = 1'b0;
   rsp_t mon_e;
   aph_t mon_a;

   // Slave model: data phase starts when the master's advance rule fires
   logic        sl_dv;
   logic [31:0] sl_addr;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sl_dv   <= 1'b0;
         sl_addr <= '0;
      end else if (HREADY || !sl_dv) begin
         sl_dv   <= (HTRANS == 2'b10);
         sl_addr <= HADDR;
      end
   end

   assign HRDATA = sl_addr + 32'h100;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (rstn && o_rsp_valid) begin
         rsp_cnt++;
         rsp_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("rsp_write", o_rsp_write, mon_e.wr);
            chk("rsp_err", o_rsp_err, mon_e.err);
            chk("rsp_data", o_rd_data, mon_e.data);
         end
      end
      if (rstn && HTRANS == 2'b10) begin
         ns_cyc.push_back(cyc);
         if (aph_en) begin
            if (aq.size() == 0) begin
               chk("aph_unexpected", 1, 0);
            end else begin
               mon_a = aq.pop_front();
               chk("aph_haddr", HADDR, mon_a.addr);
               chk("aph_hsize", HSIZE, mon_a.size);
               chk("aph_hwrite", HWRITE, mon_a.wr);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void expect_rsp(input logic w, input logic er, input logic [31:0] ea);
      rsp_t r;
      r.wr   = w;
      r.err  = er;
      r.data = (w || er) ? 32'h0 : ea + 32'h100;
      sb.push_back(r);
   endfunction

   task automatic push_cmd(
      input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] wd,
      input logic [31:0] ea, input logic [2:0] es, input logic er
   );
      aph_t ap;
      int   n = 0;
      i_valid   = 1'b1;
      i_addr    = a;
      i_rd0_wr1 = w;
      i_size    = s;
      i_wr_data = wd;
      while (!o_ready && n < 200) begin
         tick();
         n++;
      end
      if (!o_ready) chk("push_timeout", 0, 1);
      expect_rsp(w, er, ea);
      ap.addr = ea;
      ap.wr   = w;
      ap.size = es;
      aq.push_back(ap);
      tick();
      i_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      chk(nm, sb.size(), 0);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_htrans"}, HTRANS, 2'b00);
      chk({tag, "_haddr"}, HADDR, 0);
      chk({tag, "_hwdata"}, HWDATA, 0);
      chk({tag, "_hwrite"}, HWRITE, 0);
      chk({tag, "_hsize"}, HSIZE, 3'b010);
      chk({tag, "_hburst"}, HBURST, 0);
      chk({tag, "_hmastlock"}, HMASTLOCK, 0);
      chk({tag, "_ready"}, o_ready, 1);
      chk({tag, "_rsp_valid"}, o_rsp_valid, 0);
      chk({tag, "_rsp_write"}, o_rsp_write, 0);
      chk({tag, "_rsp_err"}, o_rsp_err, 0);
      chk({tag, "_rd_data"}, o_rd_data, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int r0;
      tbl[0] = '{32'h0000, 1'b0, 3'd2, 32'h0, 32'h0000, 3'd2};
      tbl[1] = '{32'h0004, 1'b0, 3'd2, 32'h0, 32'h0004, 3'd2};
      tbl[2] = '{32'h0008, 1'b0, 3'd2, 32'h0, 32'h0008, 3'd2};
      tbl[3] = '{32'h000C, 1'b0, 3'd2, 32'h0, 32'h000C, 3'd2};
      tbl[4] = '{32'h1003, 1'b0, 3'd3, 32'h0, 32'h1000, 3'd2};
      tbl[5] = '{32'h2003, 1'b1, 3'd0, 32'hAA, 32'h2003, 3'd0};
      tbl[6] = '{32'h2003, 1'b0, 3'd1, 32'h0, 32'h2002, 3'd1};
      tbl[7] = '{32'h2007, 1'b1, 3'd7, 32'h12345678, 32'h2004, 3'd2};

      #2 rstn = 1'b0;
      tick();
      tick();
      reset_checks("rst");
      rstn = 1'b1;
      tick();

      // Single write: NONSEQ cycle 1, data cycle 2, response cycle 3
      push_cmd(32'h1000, 1'b1, 3'd2, 32'hDEADBEEF, 32'h1000, 3'd2, 1'b0);
      chk("t1_c0_idle", HTRANS, 2'b00);
      tick();
      chk("t1_c1_htrans", HTRANS, 2'b10);
      chk("t1_c1_haddr", HADDR, 32'h1000);
      chk("t1_c1_hwrite", HWRITE, 1);
      tick();
      chk("t1_c2_hwdata", HWDATA, 32'hDEADBEEF);
      tick();
      chk("t1_c3_rsp_valid", o_rsp_valid, 1);
      chk("t1_c3_rsp_write", o_rsp_write, 1);
      drain("t1_drain");

      // Vector table: back-to-back reads, then size clamp and alignment
      aq.delete();
      aph_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) begin
            ns_cyc.delete();
            rsp_cyc.delete();
         end
         push_cmd(tbl[i].addr, tbl[i].wr, tbl[i].size, tbl[i].wdata,
                  tbl[i].exp_addr, tbl[i].exp_size, 1'b0);
         if (i == 3) begin
            drain("t2_drain");
            chk("t2_ns_count", ns_cyc.size(), 4);
            chk("t2_rsp_count", rsp_cyc.size(), 4);
            if (ns_cyc.size() == 4 && rsp_cyc.size() == 4) begin
               for (int k = 1; k < 4; k++) begin
                  chk("t2_ns_consec", ns_cyc[k] - ns_cyc[0], k);
                  chk("t2_rsp_consec", rsp_cyc[k] - rsp_cyc[0], k);
               end
               chk("t2_first_rsp_lat", rsp_cyc[0] - ns_cyc[0], 2);
            end
         end
      end
      drain("tbl_drain");
      chk("tbl_aq_empty", aq.size(), 0);
      aph_en = 1'b0;

      // Backpressure: with HREADY low, D + A + 4 FIFO slots absorb 6
      HREADY = 1'b0;
      acc = 0;
      for (int i = 0; i < 7; i++) begin
         if (!o_ready) break;
         i_valid   = 1'b1;
         i_addr    = 32'h300 + 32'(4 * i);
         i_rd0_wr1 = i[0];
         i_size    = 3'd2;
         i_wr_data = 32'hA000 + 32'(i);
         expect_rsp(i[0], 1'b0, 32'h300 + 32'(4 * i));
         tick();
         i_valid = 1'b0;
         acc++;
      end
      chk("t3_accepted", acc, 6);
      chk("t3_ready_low", o_ready, 0);
      chk("t3_no_rsp_stalled", o_rsp_valid, 0);
      HREADY = 1'b1;
      push_cmd(32'h318, 1'b0, 3'd2, 32'h0, 32'h318, 3'd2, 1'b0);
      drain("t3_drain");

`ifdef AHB_MST_ERR_RESP_EN
      // Read takes a two-cycle ERROR; queued write is re-driven afterwards
      push_cmd(32'h40, 1'b0, 3'd2, 32'h0, 32'h40, 3'd2, 1'b1);
      push_cmd(32'h44, 1'b1, 3'd2, 32'h5555AAAA, 32'h44, 3'd2, 1'b0);
      tick();
      chk("t5_c2_htrans", HTRANS, 2'b10);
      chk("t5_c2_haddr", HADDR, 32'h44);
      HREADY = 1'b0;
      HRESP  = 1'b1;
      tick();
      chk("t5_c3_idle", HTRANS, 2'b00);
      chk("t5_c3_no_rsp", o_rsp_valid, 0);
      HREADY = 1'b1;
      tick();
      chk("t5_c4_rsp_valid", o_rsp_valid, 1);
      chk("t5_c4_rsp_err", o_rsp_err, 1);
      chk("t5_c4_redrive", HTRANS, 2'b10);
      chk("t5_c4_haddr", HADDR, 32'h44);
      HRESP = 1'b0;
      drain("t5_drain");
`else
      // HRESP has no effect in the default build
      HRESP = 1'b1;
      push_cmd(32'h50, 1'b0, 3'd2, 32'h0, 32'h50, 3'd2, 1'b0);
      push_cmd(32'h54, 1'b1, 3'd2, 32'h77, 32'h54, 3'd2, 1'b0);
      drain("t5_drain");
      HRESP = 1'b0;
`endif

      // Reset with one transfer in D, one in A and two queued
      HREADY = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push_cmd(32'h600 + 32'(4 * i), 1'b0, 3'd2, 32'h0, 32'h600 + 32'(4 * i), 3'd2, 1'b0);
      end
      chk("t6_pre_htrans", HTRANS, 2'b10);
      chk("t6_pre_haddr", HADDR, 32'h604);
      rstn = 1'b0;
      #1;
      sb.delete();
      aq.delete();
      reset_checks("t6");
      tick();
      HREADY = 1'b1;
      tick();
      rstn = 1'b1;
      r0 = rsp_cnt;
      for (int i = 0; i < 10; i++) tick();
      chk("t6_no_rsp", rsp_cnt - r0, 0);
      chk("t6_idle", HTRANS, 2'b00);
      chk("t6_ready", o_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
